// File: rtl/bits_to_ascii_converter_if.sv
// ----------------------------------------------------------------------------
// bits_to_ascii_converter_if
//   Groups the word handshake and UART TX signals of bits_to_ascii_converter.
//   master: the side that supplies words and the UART busy indication
//           (processor/debug logic plus UART TX core).
//   slave : the converter itself.
// Signals
//   bit_data   [WIDTH-1:0]  word to transmit
//   data_valid              request to transmit bit_data
//   ready                   converter idle, accepts bit_data this cycle
//   tx_byte    [7:0]        ASCII character to the UART
//   tx_start                one-cycle load pulse for the UART
//   tx_busy                 UART busy with a character
//   done                    one-cycle pulse after the last character finished
// ----------------------------------------------------------------------------
interface bits_to_ascii_converter_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] bit_data;
  logic             data_valid;
  logic             ready;
  logic [7:0]       tx_byte;
  logic             tx_start;
  logic             tx_busy;
  logic             done;

  modport master (
    output bit_data, data_valid, tx_busy,
    input  ready, tx_byte, tx_start, done
  );

  modport slave (
    input  bit_data, data_valid, tx_busy,
    output ready, tx_byte, tx_start, done
  );
endinterface

// File: rtl/bits_to_ascii_converter.sv
// ----------------------------------------------------------------------------
// bits_to_ascii_converter
//   Takes a WIDTH-bit word and streams it to a UART transmitter as ASCII
//   '0'/'1' characters, MSB first, optionally followed by CR LF.
// Parameters
//   WIDTH        characters per word (excluding the CR LF trailer)
//   APPEND_CRLF  1: send 8'h0D, 8'h0A after the last bit; 0: no trailer
// Ports
//   clk   system clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   slave side of bits_to_ascii_converter_if (word handshake + UART TX)
// ----------------------------------------------------------------------------
module bits_to_ascii_converter #(
  parameter int WIDTH       = 32,
  parameter bit APPEND_CRLF = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  bits_to_ascii_converter_if.slave    bus
);

  localparam int CNT_W    = $clog2(WIDTH + 2);
  localparam int LAST_IDX = APPEND_CRLF ? (WIDTH + 1) : (WIDTH - 1);

  localparam logic [CNT_W-1:0] CNT_WIDTH = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(LAST_IDX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_HOLD,
    S_WAIT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0] char_cnt;
  logic [7:0]       tx_byte_r;
  logic             tx_start_r;
  logic             done_r;

  // Character for the current counter position. Data bits come from the MSB
  // of the shift register; positions past the data bits are the CR LF trailer
  // (only reachable when APPEND_CRLF is set, since the counter stops earlier
  // otherwise).
  function automatic logic [7:0] next_char(input logic [CNT_W-1:0] cnt,
                                           input logic             msb);
    logic [7:0] ch;
    if (cnt < CNT_WIDTH) begin
      ch = {7'b0011000, msb};
    end else if (cnt == CNT_WIDTH) begin
      ch = 8'h0D;
    end else begin
      ch = 8'h0A;
    end
    return ch;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      shift_reg  <= '0;
      char_cnt   <= '0;
      tx_byte_r  <= 8'h00;
      tx_start_r <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      // Pulses default low; each is raised for exactly one cycle below.
      tx_start_r <= 1'b0;
      done_r     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.data_valid) begin
            shift_reg <= bus.bit_data;
            char_cnt  <= '0;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!bus.tx_busy) begin
            tx_byte_r  <= next_char(char_cnt, shift_reg[WIDTH-1]);
            tx_start_r <= 1'b1;
            if (char_cnt < CNT_WIDTH) begin
              shift_reg <= shift_reg << 1;
            end
            state <= S_HOLD;
          end
        end
        // Dead cycle so the UART has time to raise tx_busy before it is
        // examined in S_WAIT.
        S_HOLD: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (!bus.tx_busy) begin
            char_cnt <= char_cnt + 1'b1;
            if (char_cnt == CNT_LAST) begin
              done_r <= 1'b1;
              state  <= S_IDLE;
            end else begin
              state <= S_ISSUE;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ready    = (state == S_IDLE);
  assign bus.tx_byte  = tx_byte_r;
  assign bus.tx_start = tx_start_r;
  assign bus.done     = done_r;

endmodule
